// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter stage for the clock datapath (sec/min/hr).
// Supports clear, checked preset load, a BCD decode, carry/borrow and wrap flag.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   clr       synchronous clear to RESET_VAL
//   en        count enable (0 hold, 1 step)
//   up        direction (1 increment, 0 decrement)
//   load      synchronous preset load of data
//   data      preset value, rejected when >= MODULUS
//   count     registered counter value
//   tens      BCD tens digit of count (4'hF when MODULUS > 100)
//   ones      BCD ones digit of count (4'hF when MODULUS > 100)
//   rco       combinational carry/borrow for cascading
//   wrap      one-cycle pulse after a wrap
//   load_err  one-cycle pulse after a rejected load
module modn_updown_counter #(
  parameter int MODULUS   = 60,
  parameter int WIDTH     = 7,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             rco,
  output logic             wrap,
  output logic             load_err
);

  // Limits are held one bit wider than count so that
  // MODULUS == 2**WIDTH is still representable.
  localparam int MAXV = MODULUS - 1;
  localparam int ONEI = 1;

  localparam logic [WIDTH:0]   MOD_X = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0]   MAX_X = MAXV[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_W = MAXV[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_W = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_W = ONEI[WIDTH-1:0];

  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   data_x;
  logic             at_max;
  logic             at_zero;
  logic             data_ok;

  logic             do_clr;
  logic             do_load;
  logic             do_step;

  logic [WIDTH-1:0] cnt_d;
  logic             wrap_d;
  logic             lerr_d;

  assign cnt_x   = {1'b0, count};
  assign data_x  = {1'b0, data};
  assign at_max  = (cnt_x == MAX_X);
  assign at_zero = (count == '0);
  assign data_ok = (data_x < MOD_X);

  // One action per edge: clr beats load beats en.
  assign do_clr  = clr;
  assign do_load = load & ~clr;
  assign do_step = en & ~load & ~clr;

  // Terminal count for the current direction; feeds
  // the next stage's en within the same cycle.
  assign rco = ~rst & do_step &
               (up ? at_max : at_zero);

  always_comb begin
    cnt_d  = count;
    wrap_d = 1'b0;
    lerr_d = 1'b0;
    unique case (1'b1)
      do_clr: begin
        cnt_d = RST_W;
      end
      do_load: begin
        if (data_ok) begin
          cnt_d = data;
        end else begin
          lerr_d = 1'b1;
        end
      end
      do_step: begin
        if (up) begin
          if (at_max) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end else begin
            cnt_d = count + ONE_W;
          end
        end else begin
          if (at_zero) begin
            cnt_d  = MAX_W;
            wrap_d = 1'b1;
          end else begin
            cnt_d = count - ONE_W;
          end
        end
      end
      default: begin
        cnt_d = count;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= RST_W;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= cnt_d;
      wrap     <= wrap_d;
      load_err <= lerr_d;
    end
  end

  // Display decode; a three-digit range has no
  // two-digit BCD form, so it reads as blank.
  generate
    if (MODULUS > 100) begin : g_no_bcd
      assign tens = 4'hF;
      assign ones = 4'hF;
    end else begin : g_bcd
      int cnt_i;
      assign cnt_i = 32'(count);
      assign tens  = 4'(cnt_i / 10);
      assign ones  = 4'(cnt_i % 10);
    end
  endgenerate

endmodule

// File: doc/modn_updown_counter.md
Name: modn_updown_counter

Overview:
Parametrised modulo-N up/down counter for the clock datapath. It is the general building block for seconds, minutes and hours stages (N = 60, 60, 24), and can be cascaded through a combinational carry/borrow. It adds synchronous clear, checked preset load, down-counting, a BCD digit decode for the display drivers, and a registered wrap pulse for event logging.

Parameters:
MODULUS, 60, count range 0..MODULUS-1; legal range 2..2**WIDTH; BCD outputs meaningful only for MODULUS <= 100.
WIDTH, 7, bit width of count and data.
RESET_VAL, 0, value loaded by rst and clr; must be < MODULUS.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  asynchronous reset, active-high.
clr  input  1  synchronous clear to RESET_VAL.
en  input  1  count enable; 0 = hold, 1 = step by one.
up  input  1  direction; 1 = increment, 0 = decrement.
load  input  1  synchronous preset load of data.
data  input  WIDTH  preset value.
count  output  WIDTH  current counter value, registered.
tens  output  4  BCD tens digit of count, combinational decode.
ones  output  4  BCD ones digit of count, combinational decode.
rco  output  1  combinational carry/borrow for cascading.
wrap  output  1  registered one-cycle pulse after a wrap.
load_err  output  1  registered one-cycle pulse after a rejected load.

Behaviour:
- Reset (rst = 1, asynchronous, immediate):
  - count = RESET_VAL, wrap = 0, load_err = 0.
  - tens/ones and rco follow combinationally.
- Priority at each rising edge: rst > clr > load > en. Exactly one action per cycle.
- clr = 1:
  - count <= RESET_VAL.
  - wrap <= 0, load_err <= 0.
- load = 1 (clr = 0):
  - data < MODULUS: count <= data, load_err <= 0.
  - data >= MODULUS: count unchanged, load_err <= 1 for one cycle.
  - en ignored in both cases; no wrap.
- en = 1, up = 1 (no clr/load):
  - count == MODULUS-1: count <= 0, wrap <= 1.
  - Otherwise: count <= count+1, wrap <= 0.
- en = 1, up = 0 (no clr/load):
  - count == 0: count <= MODULUS-1, wrap <= 1.
  - Otherwise: count <= count-1, wrap <= 0.
- en = 0 (no clr/load): count holds; wrap <= 0; load_err <= 0.
- Arithmetic: count never leaves 0..MODULUS-1. Compares use WIDTH+1 bits so MODULUS = 2**WIDTH wraps correctly.
- rco = en & ~load & ~clr & ((up & count == MODULUS-1) | (~up & count == 0)).
  - Zero latency; drives the next stage's en in the same cycle.
  - Forced 0 while rst is asserted.
- tens/ones:
  - tens = count / 10, ones = count % 10, combinational.
  - If MODULUS > 100, both are tied to 4'hF.
- wrap and load_err: single-cycle pulses, one cycle after the causing edge; they never stretch.
- rst asserted mid-operation: all state clears at once. The first edge after release acts on the current inputs.
- Direction change between cycles is legal. A wrap applies the current cycle's up value.

Test Plan:
1. MODULUS = 60. Release rst, en = 1, up = 1 for 60 cycles -> count runs 0..59 then 0; rco = 1 only while count = 59; wrap = 1 in the cycle after 59 -> 0; tens/ones = 5/9 at count 59.
2. up = 0 from count 0 with en = 1 -> count = 59 next edge, wrap pulses once, rco = 1 while count = 0; then 58, 57 with rco = 0.
3. load = 1, data = 45 with en = 1 -> count = 45, no wrap. load = 1, data = 60 -> count stays 45, load_err pulses for one cycle.
4. Same edge clr = 1, load = 1, data = 30, en = 1 -> count = RESET_VAL. Then en = 0 for 5 cycles -> count holds, rco = 0.
5. Cascade 60/60/24 (hours MODULUS = 24) from 23:59:59 counting up -> next edge 00:00:00, all three wrap pulses together. Assert rst mid-count -> all outputs 0 immediately, without a clock edge.
6. WIDTH = 3, MODULUS = 8, up from 7 -> 0 with wrap; check the full-range compare. MODULUS = 200 -> tens/ones read 4'hF.
